// File: rtl/fir_conv_ci.sv
// fir_conv_ci: sequential TAPS-tap FIR (one MAC per enabled cycle) with coefficient load/read, history clear and start/done handshake
// Ports: clk, reset (async, active high), clk_en, start, n (opcode), dataa (coef/sample), datab (coef index) -> result, done
module fir_conv_ci #(
  parameter int TAPS  = 16,
  parameter int SHIFT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [1:0]  n,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done
);
  localparam int AW = $clog2(TAPS);
  typedef enum logic [1:0] {IDLE, MAC, FINISH} state_t;
  state_t state_q, state_d;
  logic signed [15:0] coef_q [TAPS];
  logic signed [15:0] hist_q [TAPS];
  logic [AW-1:0] wp_q, rp_q, k_q, idx;
  logic signed [39:0] acc_q, prod, rnd, sh;
  logic signed [15:0] y;
  logic [31:0] result_q;
  logic done_q;
  logic unused;
  assign unused = ^{dataa[31:16], datab[31:AW]};
  assign idx = datab[AW-1:0];
  assign result = result_q;
  assign done = done_q;
  assign prod = 40'(coef_q[k_q] * hist_q[rp_q]);
  assign rnd = acc_q + (40'sd1 <<< (SHIFT - 1));
  assign sh = rnd >>> SHIFT;
  assign y = sh > 40'sd32767 ? 16'sh7fff : sh < -40'sd32768 ? 16'sh8000 : sh[15:0];
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (start && n == 2'd1) ? MAC : IDLE;
      MAC:     state_d = (k_q == AW'(TAPS - 1)) ? FINISH : MAC;
      default: state_d = IDLE;
    endcase
  end
  // rp_q walks backwards from the newest sample, so tap k always reads x[newest-k]
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      wp_q     <= '0;
      rp_q     <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        coef_q[i] <= '0;
        hist_q[i] <= '0;
      end
    end else if (clk_en) begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          case (n)
            2'd0: begin
              coef_q[idx] <= dataa[15:0];
              result_q    <= '0;
              done_q      <= 1'b1;
            end
            2'd1: begin
              hist_q[wp_q] <= dataa[15:0];
              rp_q         <= wp_q;
              wp_q         <= (wp_q == AW'(TAPS - 1)) ? '0 : wp_q + 1'b1;
              k_q          <= '0;
              acc_q        <= '0;
            end
            2'd2: begin
              for (int i = 0; i < TAPS; i++) hist_q[i] <= '0;
              wp_q     <= '0;
              result_q <= '0;
              done_q   <= 1'b1;
            end
            default: begin
              result_q <= {{16{coef_q[idx][15]}}, coef_q[idx]};
              done_q   <= 1'b1;
            end
          endcase
        end
        MAC: begin
          acc_q <= acc_q + prod;
          k_q   <= k_q + 1'b1;
          rp_q  <= (rp_q == '0) ? AW'(TAPS - 1) : rp_q - 1'b1;
        end
        default: begin
          result_q <= {{16{y[15]}}, y};
          done_q   <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fir_conv_ci.sv
// tb_fir_conv_ci: directed self-checking bench for fir_conv_ci
module tb_fir_conv_ci;
  logic clk = 1'b0, reset = 1'b1, clk_en = 1'b1, start = 1'b0;
  logic [1:0] n = '0;
  logic [31:0] dataa = '0, datab = '0, result;
  logic done;
  int total = 0, bad = 0;
  fir_conv_ci dut (.clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .n(n),
                   .dataa(dataa), .datab(datab), .result(result), .done(done));
  always #5 clk = ~clk;
  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [3:0] b, output int lat);
    @(negedge clk);
    start = 1'b1; n = op; dataa = {16'h0, a}; datab = {28'h0, b};
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic test_reset;
    int lat;
    #12;
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=%h", result, 32'h0); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    @(negedge clk) reset = 1'b0;
    issue(2'd1, 16'h1234, 4'd0, lat);
    total++; if (lat !== 17) begin bad++; $display("FAIL push_latency got=%0d exp=17", lat); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL zero_coef got=%h exp=%h", result, 32'h0); end
  endtask
  task automatic test_load;
    int lat;
    issue(2'd0, 16'h7fff, 4'd0, lat);
    total++; if (lat !== 0 || result !== 32'h0) begin bad++; $display("FAIL load got=%0d/%h exp=0/%h", lat, result, 32'h0); end
    issue(2'd0, 16'h8000, 4'd5, lat);
    issue(2'd3, 16'h0, 4'd5, lat);
    total++; if (result !== 32'hffff8000) begin bad++; $display("FAIL read_coef got=%h exp=%h", result, 32'hffff8000); end
    issue(2'd0, 16'h0, 4'd5, lat);
    issue(2'd1, 16'd1000, 4'd0, lat);
    total++; if (lat !== 17 || result !== 32'h3e8) begin bad++; $display("FAIL push_1000 got=%0d/%h exp=17/%h", lat, result, 32'h3e8); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_one_cycle got=%b exp=0", done); end
  endtask
  task automatic test_back_to_back;
    int lat;
    issue(2'd0, 16'h1357, 4'd9, lat);
    start = 1'b1; n = 2'd3; datab = 32'd9;
    @(negedge clk);
    start = 1'b0;
    total++; if (done !== 1'b1 || result !== 32'h1357) begin bad++; $display("FAIL back_to_back got=%b/%h exp=1/%h", done, result, 32'h1357); end
    issue(2'd0, 16'h0, 4'd9, lat);
  endtask
  task automatic test_average;
    int lat;
    for (int i = 0; i < 16; i++) issue(2'd0, 16'h4000, 4'(i), lat);
    for (int i = 0; i < 16; i++) issue(2'd1, 16'd100, 4'd0, lat);
    total++; if (result !== 32'h320) begin bad++; $display("FAIL avg_full got=%h exp=%h", result, 32'h320); end
    issue(2'd1, 16'd0, 4'd0, lat);
    total++; if (result !== 32'h2ee) begin bad++; $display("FAIL avg_wrap got=%h exp=%h", result, 32'h2ee); end
  endtask
  task automatic test_saturate;
    int lat;
    for (int i = 0; i < 16; i++) issue(2'd0, 16'h7fff, 4'(i), lat);
    for (int i = 0; i < 16; i++) issue(2'd1, 16'h7fff, 4'd0, lat);
    total++; if (result !== 32'h7fff) begin bad++; $display("FAIL sat_pos got=%h exp=%h", result, 32'h7fff); end
    issue(2'd2, 16'h0, 4'd0, lat);
    total++; if (lat !== 0 || result !== 32'h0) begin bad++; $display("FAIL clear got=%0d/%h exp=0/%h", lat, result, 32'h0); end
    for (int i = 0; i < 16; i++) issue(2'd1, 16'h8000, 4'd0, lat);
    total++; if (result !== 32'hffff8000) begin bad++; $display("FAIL sat_neg got=%h exp=%h", result, 32'hffff8000); end
  endtask
  task automatic test_stall;
    int lat, dones;
    issue(2'd2, 16'h0, 4'd0, lat);
    issue(2'd1, 16'd200, 4'd0, lat);
    total++; if (result !== 32'd200) begin bad++; $display("FAIL stall_pre got=%h exp=%h", result, 32'd200); end
    @(negedge clk);
    start = 1'b1; n = 2'd1; dataa = 32'h0000fed4;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 80) begin
      start = (lat == 3 || lat == 4);
      n = 2'd2;
      clk_en = !(lat >= 6 && lat < 11);
      @(negedge clk);
      lat++;
    end
    start = 1'b0; clk_en = 1'b1;
    total++; if (lat !== 22) begin bad++; $display("FAIL stall_latency got=%0d exp=22", lat); end
    total++; if (result !== 32'hffffff9c) begin bad++; $display("FAIL stall_result got=%h exp=%h", result, 32'hffffff9c); end
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      dones += int'(done);
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL extra_done got=%0d exp=0", dones); end
  endtask
  task automatic test_reset_mid;
    int lat, dones;
    @(negedge clk);
    start = 1'b1; n = 2'd1; dataa = 32'd1000;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++; if (result !== 32'h0 || done !== 1'b0) begin bad++; $display("FAIL async_reset got=%h/%b exp=%h/0", result, done, 32'h0); end
    @(negedge clk) reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      dones += int'(done);
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL aborted_done got=%0d exp=0", dones); end
    issue(2'd3, 16'h0, 4'd1, lat);
    total++; if (result !== 32'h0) begin bad++; $display("FAIL coef_cleared got=%h exp=%h", result, 32'h0); end
    issue(2'd0, 16'h7fff, 4'd0, lat);
    issue(2'd1, 16'd1000, 4'd0, lat);
    total++; if (lat !== 17 || result !== 32'h3e8) begin bad++; $display("FAIL post_reset got=%0d/%h exp=17/%h", lat, result, 32'h3e8); end
  endtask
  initial begin
    test_reset;
    test_load;
    test_back_to_back;
    test_average;
    test_saturate;
    test_stall;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fir_conv_ci.md
FIR_CONV_CI -- requirements
Module: fir_conv_ci

Interface
REQ-001 Parameter TAPS, default 16, number of filter taps and history depth.
REQ-002 Parameter SHIFT, default 15, Q-format fraction bits of the coefficients.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 clk_en  input  1  clock enable, active high; all state frozen while low.
REQ-006 start  input  1  one-cycle request pulse, sampled only when clk_en=1.
REQ-007 n  input  2  opcode: 0=LOAD_COEF, 1=PUSH, 2=CLEAR, 3=READ_COEF.
REQ-008 dataa  input  32  bits[15:0] = signed coefficient (LOAD_COEF) or signed sample (PUSH).
REQ-009 datab  input  32  bits[3:0] = coefficient index for LOAD_COEF/READ_COEF; upper bits ignored.
REQ-010 result  output  32  operation result, valid while done=1.
REQ-011 done  output  1  completion pulse, high exactly one enabled cycle per accepted start.

Function
REQ-012 Storage: TAPS x 16-bit signed coefficient registers, TAPS x 16-bit signed circular sample history with write pointer, 40-bit signed accumulator.
REQ-013 States: IDLE, MAC, FINISH; start is accepted only in IDLE with clk_en=1.
REQ-014 start in MAC or FINISH shall be ignored; no state, history or coefficient change.
REQ-015 LOAD_COEF: coef[datab[3:0]] <= dataa[15:0]; done=1 and result=0 on the next enabled edge; state stays IDLE.
REQ-016 READ_COEF: result <= sign-extended coef[datab[3:0]], done=1 on the next enabled edge.
REQ-017 CLEAR: all history entries and write pointer <= 0, coefficients unchanged, result=0, done=1 on the next enabled edge.
REQ-018 PUSH: at the accepting edge the sample is written at the write pointer, pointer increments modulo TAPS, accumulator clears, state -> MAC.
REQ-019 MAC: one tap per enabled edge, acc += coef[k] * x[newest-k], k=0..TAPS-1, full 32-bit signed products; state -> FINISH after tap TAPS-1.
REQ-020 FINISH: y = (acc + 2^(SHIFT-1)) >>> SHIFT (arithmetic); saturate to [-32768, 32767]; result <= y sign-extended to 32 bits; done=1; state -> IDLE.
REQ-021 PUSH latency: done high during the cycle after the (TAPS+1)-th enabled edge following the accepting edge (17 enabled edges at TAPS=16).
REQ-022 Wrap-around: after more than TAPS pushes the oldest sample is overwritten; x[newest-k] with no prior push reads 0.
REQ-023 done clears on the next enabled edge; result holds its value until the next completion.
REQ-024 clk_en=0 mid-MAC stalls the tap counter, accumulator and state; resuming completes with an identical result.
REQ-025 Back-to-back: a start in the IDLE cycle where done=1 is accepted.

Reset
REQ-026 reset=1 forces result=0, done=0, state IDLE, tap counter 0, write pointer 0, accumulator 0, all history and coefficients 0, immediately and independent of clk/clk_en.
REQ-027 reset during MAC aborts the operation; no done pulse is produced for it.

Verification
REQ-028 Assert reset, release -> result=0x00000000, done=0; PUSH 0x1234 with all-zero coefs -> result=0x00000000 after 17 enabled edges.
REQ-029 LOAD coef[0]=0x7FFF, others 0; PUSH 1000 -> result=0x000003E8 (1000), done exactly one cycle.
REQ-030 All coefs 0x4000; PUSH 100 sixteen times -> 16th result=0x00000320 (800); 17th PUSH of 0 -> 0x000002EE (750).
REQ-031 All coefs 0x7FFF; sixteen PUSHes of 0x7FFF -> 0x00007FFF; CLEAR then sixteen PUSHes of 0x8000 -> 0xFFFF8000.
REQ-032 Extra start pulses during MAC and clk_en held low 5 cycles mid-MAC -> no extra done, result equal to unstalled run, latency +5 cycles.
REQ-033 Reset asserted at MAC tap 8 -> no done; subsequent PUSH 1000 with coef[0]=0x7FFF reloaded -> 1000 (history and coefs cleared).
